// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a byte FIFO: 8 data bits, no parity,
// 1 or 2 stop bits, zero-gap back-to-back frames, sticky overflow.
module uart_tx_fifo #(
  parameter int ClkFrequency = 50000000,
  parameter int Baud         = 115200,
  parameter int Depth        = 16,
  parameter int StopBits     = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [7:0]             wr_data,
  input  logic                   ovf_clr,
  output logic                   TxD,
  output logic                   TxD_busy,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(Depth):0] count,
  output logic                   overflow,
  output logic                   frame_done
);

  localparam int AW        = $clog2(Depth);
  localparam int BitCycles = ClkFrequency / Baud;
  localparam int CW        = (BitCycles > 1) ? $clog2(BitCycles) : 1;

  localparam logic [CW-1:0] LastCnt  = CW'(BitCycles - 1);
  localparam logic [AW:0]   FullCnt  = (AW+1)'(Depth);
  localparam logic          LastStop = 1'(StopBits - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  logic [7:0]    r_mem [Depth];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          r_ovf;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic          r_stop;
  logic [7:0]    r_shift;
  logic          r_txd;
  logic          r_fd;

  logic w_tick;
  logic w_push;
  logic w_pop;
  logic w_fd;
  logic w_txd_nxt;
  logic w_busy;

  assign full       = (r_count == FullCnt);
  assign empty      = (r_count == '0);
  assign count      = r_count;
  assign overflow   = r_ovf;
  assign TxD        = r_txd;
  assign TxD_busy   = w_busy;
  assign frame_done = r_fd;

  // A write against a full FIFO is dropped even if a pop frees a slot.
  assign w_push = wr_en & ~full;
  assign w_tick = (r_cnt == '0);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (wr_en && full) begin
        r_ovf <= 1'b1;
      end else if (ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_fd        = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (w_tick) begin
          w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (w_tick && (r_bit == 3'd7)) begin
          w_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (w_tick && (r_stop == LastStop)) begin
          w_fd = 1'b1;
          if (!empty) begin
            w_pop       = 1'b1;
            w_state_nxt = S_START;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
    endcase
  end

  always_comb begin
    w_txd_nxt = 1'b1;
    w_busy    = 1'b1;
    unique case (r_state)
      S_IDLE:  w_busy    = 1'b0;
      S_START: w_txd_nxt = 1'b0;
      S_DATA:  w_txd_nxt = r_shift[0];
      S_STOP:  w_txd_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_bit   <= '0;
      r_stop  <= 1'b0;
      r_shift <= '0;
    end else if (w_pop) begin
      r_shift <= r_mem[r_rptr];
      r_cnt   <= LastCnt;
      r_bit   <= '0;
      r_stop  <= 1'b0;
    end else if (w_state_nxt == S_IDLE) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= LastCnt;
      if (r_state == S_DATA) begin
        r_shift <= r_shift >> 1;
        r_bit   <= r_bit + 3'd1;
      end
      if (r_state == S_STOP) begin
        r_stop <= r_stop + 1'b1;
      end
    end else begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_txd <= 1'b1;
      r_fd  <= 1'b0;
    end else begin
      r_txd <= w_txd_nxt;
      r_fd  <= w_fd;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: cycle-exact reference model at defaults
// plus a fast 8-cycle-bit instance with one stop bit.
module tb_uart_tx_fifo;

  localparam int Bc = 50000000 / 115200;
  localparam int Sb = 2;
  localparam int Dp = 16;
  localparam int Fc = Bc * (9 + Sb);

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       ovf_clr;
  logic       TxD;
  logic       TxD_busy;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       overflow;
  logic       frame_done;

  logic       f_reset;
  logic       f_wr_en;
  logic [7:0] f_wr_data;
  logic       f_ovf_clr;
  logic       f_TxD;
  logic       f_busy;
  logic       f_full;
  logic       f_empty;
  logic [2:0] f_count;
  logic       f_ovf;
  logic       f_fd;

  uart_tx_fifo dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .ovf_clr(ovf_clr), .TxD(TxD), .TxD_busy(TxD_busy), .full(full),
    .empty(empty), .count(count), .overflow(overflow),
    .frame_done(frame_done)
  );

  uart_tx_fifo #(
    .ClkFrequency(800), .Baud(100), .Depth(4), .StopBits(1)
  ) dut_f (
    .clk(clk), .reset(f_reset), .wr_en(f_wr_en), .wr_data(f_wr_data),
    .ovf_clr(f_ovf_clr), .TxD(f_TxD), .TxD_busy(f_busy), .full(f_full),
    .empty(f_empty), .count(f_count), .overflow(f_ovf),
    .frame_done(f_fd)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0]  m_q[$];
  logic        m_ovf;
  logic        m_fd;
  logic [7:0]  m_byte;
  int          k;
  int          m_p;
  logic [10:0] m_exp;
  logic [10:0] obs;

  assign obs = {TxD, TxD_busy, frame_done, overflow, full, empty, count};

  // Line level after edge k follows from the pop edge m_p alone.
  function automatic logic [10:0] calc_exp();
    logic t;
    logic b;
    int   d;
    int   n;
    t = 1'b1;
    b = 1'b0;
    if (m_p >= 0) begin
      d = k - m_p - 1;
      b = (k < m_p + Fc);
      if (d >= 0 && d < Bc) t = 1'b0;
      else if (d >= Bc && d < 9 * Bc) t = m_byte[d / Bc - 1];
    end
    n = m_q.size();
    return {t, b, m_fd, m_ovf, n == Dp, n == 0, 5'(n)};
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_ovf = 1'b0;
    m_fd  = 1'b0;
    m_p   = -1;
    m_exp = calc_exp();
  endtask

  task automatic tick();
    logic pop;
    logic fullp;
    @(posedge clk);
    k++;
    m_fd = (m_p >= 0) && (k == m_p + Fc);
    if (!reset) begin
      fullp = (m_q.size() == Dp);
      pop = (m_q.size() != 0) && (m_p < 0 || k >= m_p + Fc);
      if (pop) begin
        m_byte = m_q.pop_front();
        m_p = k;
      end
      if (wr_en && fullp) begin
        m_ovf = 1'b1;
      end else begin
        if (wr_en) m_q.push_back(wr_data);
        if (ovf_clr) m_ovf = 1'b0;
      end
    end else begin
      m_fd = 1'b0;
    end
    m_exp = calc_exp();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    wr_en = 1'b0;
    wr_data = 8'h00;
    ovf_clr = 1'b0;
    model_reset();
    #1;
    total++;
    if (obs !== m_exp) begin
      bad++;
      $display("FAIL reset_async t=%0t got=%b exp=%b", $time, obs, m_exp);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (obs !== m_exp) begin
        bad++;
        $display("FAIL reset cyc=%0d got=%b exp=%b", k, obs, m_exp);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_single();
    int n_fd;
    n_fd = 0;
    wr_en = 1'b1;
    wr_data = 8'h55;
    tick();
    wr_en = 1'b0;
    for (int i = 0; i < Fc + 20; i++) begin
      total++;
      if (obs !== m_exp) begin
        bad++;
        $display("FAIL single cyc=%0d got=%b exp=%b", k, obs, m_exp);
      end
      if (frame_done === 1'b1) n_fd++;
      tick();
    end
    total++;
    if (n_fd !== 1) begin
      bad++;
      $display("FAIL single_fd_count got=%0d exp=1", n_fd);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [3];
    int n_fd;
    int gaps;
    logic seen;
    bytes = '{8'h01, 8'h80, 8'hFF};
    n_fd = 0;
    gaps = 0;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1;
      wr_data = bytes[i];
      tick();
      total++;
      if (obs !== m_exp) begin
        bad++;
        $display("FAIL b2b_wr cyc=%0d got=%b exp=%b", k, obs, m_exp);
      end
      if (TxD_busy === 1'b1) seen = 1'b1;
    end
    wr_en = 1'b0;
    for (int i = 0; i < 3 * Fc + 20; i++) begin
      tick();
      total++;
      if (obs !== m_exp) begin
        bad++;
        $display("FAIL b2b cyc=%0d got=%b exp=%b", k, obs, m_exp);
      end
      if (frame_done === 1'b1) n_fd++;
      if (TxD_busy === 1'b1) seen = 1'b1;
      if (seen && n_fd < 3 && TxD_busy !== 1'b1) gaps++;
    end
    total++;
    if (n_fd !== 3) begin
      bad++;
      $display("FAIL b2b_fd_count got=%0d exp=3", n_fd);
    end
    total++;
    if (gaps !== 0) begin
      bad++;
      $display("FAIL b2b_busy_gap got=%0d exp=0", gaps);
    end
  endtask

  task automatic test_overflow();
    wr_en = 1'b1;
    wr_data = 8'h11;
    tick();
    wr_en = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    total++;
    if (obs !== m_exp) begin
      bad++;
      $display("FAIL ovf_pre cyc=%0d got=%b exp=%b", k, obs, m_exp);
    end
    for (int i = 0; i < 17; i++) begin
      wr_en = 1'b1;
      wr_data = 8'($urandom);
      tick();
      total++;
      if (obs !== m_exp) begin
        bad++;
        $display("FAIL ovf_fill cyc=%0d got=%b exp=%b", k, obs, m_exp);
      end
    end
    wr_en = 1'b0;
    tick();
    total++;
    if ({full, count, overflow} !== {1'b1, 5'd16, 1'b1}) begin
      bad++;
      $display("FAIL ovf_full got=%b/%0d/%b exp=1/16/1", full, count, overflow);
    end
    wr_en = 1'b1;
    ovf_clr = 1'b1;
    wr_data = 8'h77;
    tick();
    wr_en = 1'b0;
    ovf_clr = 1'b0;
    total++;
    if (obs !== m_exp) begin
      bad++;
      $display("FAIL ovf_set_wins cyc=%0d got=%b exp=%b", k, obs, m_exp);
    end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    total++;
    if (obs !== m_exp) begin
      bad++;
      $display("FAIL ovf_clr cyc=%0d got=%b exp=%b", k, obs, m_exp);
    end
    while (k + 1 < m_p + Fc) begin
      tick();
      total++;
      if (obs !== m_exp) begin
        bad++;
        $display("FAIL ovf_wait cyc=%0d got=%b exp=%b", k, obs, m_exp);
      end
    end
    wr_en = 1'b1;
    wr_data = 8'hA5;
    tick();
    wr_en = 1'b0;
    total++;
    if ({count, overflow} !== {5'd15, 1'b1}) begin
      bad++;
      $display("FAIL ovf_pop_full got=%0d/%b exp=15/1", count, overflow);
    end
    total++;
    if (obs !== m_exp) begin
      bad++;
      $display("FAIL ovf_pop cyc=%0d got=%b exp=%b", k, obs, m_exp);
    end
  endtask

  task automatic test_reset_midframe();
    while (k < m_p + 1 + 4 * Bc + Bc / 2) begin
      tick();
      total++;
      if (obs !== m_exp) begin
        bad++;
        $display("FAIL mid_run cyc=%0d got=%b exp=%b", k, obs, m_exp);
      end
    end
    reset = 1'b1;
    model_reset();
    #1;
    total++;
    if ({TxD, TxD_busy, count} !== {1'b1, 1'b0, 5'd0}) begin
      bad++;
      $display("FAIL mid_reset got=%b/%b/%0d exp=1/0/0", TxD, TxD_busy, count);
    end
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 2 * Fc; i++) begin
      tick();
      total++;
      if (obs !== m_exp) begin
        bad++;
        $display("FAIL mid_after cyc=%0d got=%b exp=%b", k, obs, m_exp);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 20000; i++) begin
      wr_en = (i >= 100 && i < 118) || ($urandom_range(0, 799) == 0);
      wr_data = 8'($urandom);
      ovf_clr = ($urandom_range(0, 1999) == 0);
      tick();
      total++;
      if (obs !== m_exp) begin
        bad++;
        $display("FAIL random cyc=%0d got=%b exp=%b", k, obs, m_exp);
      end
    end
    wr_en = 1'b0;
    ovf_clr = 1'b0;
  endtask

  task automatic test_fast_frames();
    logic       arr [300];
    int         fdt[$];
    logic [7:0] fb [3];
    logic [7:0] dec;
    logic       st;
    logic       sp;
    int         base;
    fb = '{8'h3C, 8'hA5, 8'h0F};
    f_reset = 1'b0;
    @(posedge clk);
    #1;
    for (int e = 0; e < 300; e++) begin
      f_wr_en = 1'b0;
      if (e < 3) begin
        f_wr_en = 1'b1;
        f_wr_data = fb[e];
      end
      @(posedge clk);
      #1;
      arr[e] = f_TxD;
      if (f_fd === 1'b1) fdt.push_back(e);
    end
    f_wr_en = 1'b0;
    total++;
    if ({arr[1], arr[2]} !== 2'b10) begin
      bad++;
      $display("FAIL fast_latency got=%b%b exp=10", arr[1], arr[2]);
    end
    total++;
    if (fdt.size() !== 3) begin
      bad++;
      $display("FAIL fast_fd_count got=%0d exp=3", fdt.size());
    end else begin
      total++;
      if (fdt[0] !== 81) begin
        bad++;
        $display("FAIL fast_fd0 got=%0d exp=81", fdt[0]);
      end
      for (int j = 1; j < 3; j++) begin
        total++;
        if (fdt[j] - fdt[j-1] !== 80) begin
          bad++;
          $display("FAIL fast_period got=%0d exp=80", fdt[j] - fdt[j-1]);
        end
      end
    end
    for (int j = 0; j < 3; j++) begin
      base = 2 + 80 * j;
      st = 1'b0;
      sp = 1'b1;
      for (int t = 0; t < 8; t++) begin
        st = st | arr[base + t];
        sp = sp & arr[base + 72 + t];
      end
      for (int i = 0; i < 8; i++) dec[i] = arr[base + 8 * (i + 1) + 4];
      total++;
      if ({st, dec, sp} !== {1'b0, fb[j], 1'b1}) begin
        bad++;
        $display("FAIL fast_frame%0d got=%b/%h/%b exp=0/%h/1", j, st, dec, sp, fb[j]);
      end
    end
    total++;
    if ({arr[299], f_busy} !== 2'b10) begin
      bad++;
      $display("FAIL fast_idle got=%b%b exp=10", arr[299], f_busy);
    end
  endtask

  initial begin
    k = 0;
    m_p = -1;
    f_reset = 1'b1;
    f_wr_en = 1'b0;
    f_wr_data = 8'h00;
    f_ovf_clr = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_reset_midframe();
    test_random();
    test_fast_frames();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
